rr_mux: RTL and testbench

//   Parametrised N:1 registered multiplexer. Channel selection is round-robin

---
 rtl/rr_mux.sv | 146 ++++++++++++++
 tb/tb_rr_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux.sv
// N:1 registered multiplexer with round-robin arbitration and valid/ready handshakes.
// Optional packet locking (in_last/out_last) is enabled by defining RR_MUX_LAST_EN.
module rr_mux #(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N*WIDTH-1:0]    in_data,
   input  logic [N-1:0]          in_valid,
   output logic [N-1:0]          in_ready,
`ifdef RR_MUX_LAST_EN
   input  logic [N-1:0]          in_last,
   output logic                  out_last,
`endif
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [$clog2(N)-1:0]  out_sel
);

   localparam int SELW = $clog2(N);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  ptr_next;
   logic [SELW-1:0]  grant;
   logic [WIDTH-1:0] grant_data;
   logic [N-1:0]     eligible;
   logic             found;
   logic             load_en;
   logic             transfer;
   logic             grant_last;

   assign load_en  = !out_valid || out_ready;
   assign transfer = load_en && found;
   assign ptr_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

`ifdef RR_MUX_LAST_EN
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   state_t          state_next;
   logic [SELW-1:0] lock_ch;
   logic [SELW-1:0] lock_ch_next;

   // While a packet is open only its owner may be granted, even if it idles.
   always_comb begin
      eligible = in_valid;
      if (state == LOCKED) begin
         eligible = '0;
         eligible[lock_ch] = in_valid[lock_ch];
      end
   end

   assign grant_last = in_last[grant];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lock_ch <= '0;
      end else begin
         state   <= state_next;
         lock_ch <= lock_ch_next;
      end
   end

   always_comb begin
      state_next   = state;
      lock_ch_next = lock_ch;
      case (state)
         IDLE: begin
            if (transfer && !grant_last) begin
               state_next   = LOCKED;
               lock_ch_next = grant;
            end
         end
         LOCKED: begin
            if (transfer && grant_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_last <= 1'b0;
      end else if (transfer) begin
         out_last <= grant_last;
      end
   end
`else
   assign eligible   = in_valid;
   assign grant_last = 1'b1;
`endif

   // Search from ptr upward first, then wrap to the channels below ptr.
   always_comb begin
      found      = 1'b0;
      grant      = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && eligible[i] && (SELW'(i) >= ptr)) begin
            found      = 1'b1;
            grant      = SELW'(i);
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && eligible[i] && (SELW'(i) < ptr)) begin
            found      = 1'b1;
            grant      = SELW'(i);
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = transfer && (grant == SELW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (found) begin
            out_data  <= grant_data;
            out_sel   <= grant;
            out_valid <= 1'b1;
            if (grant_last) begin
               ptr <= ptr_next;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_rr_mux;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = $clog2(N);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [N*WIDTH-1:0]   in_data = '0;
   logic [N-1:0]         in_valid = '0;
   logic [N-1:0]         in_ready;
   logic [N-1:0]         in_last = '1;
   logic                 out_last;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [SELW-1:0]      out_sel;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef RR_MUX_LAST_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

`ifndef RR_MUX_LAST_EN
   assign out_last = 1'b1;
`endif

   // Reference model: which channel must win, expressed as a rotating search.
   bit             m_valid = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int             m_sel = 0;
   bit             m_last = 1'b0;
   int             m_ptr = 0;
   bit             m_locked = 1'b0;
   int             m_lock = 0;
   int             m_g;

   function automatic int pick(input logic [N-1:0] v, input int p, input bit lk, input int lc);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N] && (!lk || ((p + k) % N) == lc)) return (p + k) % N;
      end
      return -1;
   endfunction

   always_comb m_g = pick(in_valid, m_ptr, m_locked, m_lock);

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      r = '0;
      if ((!m_valid || out_ready) && m_g >= 0) r[m_g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_sel    <= 0;
         m_last   <= 1'b0;
         m_ptr    <= 0;
         m_locked <= 1'b0;
         m_lock   <= 0;
      end else if (!m_valid || out_ready) begin
         if (m_g >= 0) begin
            m_valid <= 1'b1;
            m_data  <= in_data[m_g*WIDTH +: WIDTH];
            m_sel   <= m_g;
            m_last  <= in_last[m_g];
            if (in_last[m_g]) begin
               m_ptr    <= (m_g + 1) % N;
               m_locked <= 1'b0;
            end else begin
               m_locked <= 1'b1;
               m_lock   <= m_g;
            end
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_output("model out_valid", 32'(out_valid), 32'(m_valid));
         check_output("model out_data", 32'(out_data), 32'(m_data));
         check_output("model out_sel", 32'(out_sel), m_sel);
         check_output("model in_ready", 32'(in_ready), 32'(exp_ready()));
`ifdef RR_MUX_LAST_EN
         check_output("model out_last", 32'(out_last), 32'(m_last));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [N-1:0] valid, input logic ready);
      in_valid  = valid;
      out_ready = ready;
   endtask

   task automatic check_beat(input string tag, input logic v, input logic [WIDTH-1:0] d, input int s);
      check_output({tag, " out_valid"}, 32'(out_valid), 32'(v));
      check_output({tag, " out_data"}, 32'(out_data), 32'(d));
      check_output({tag, " out_sel"}, 32'(out_sel), s);
   endtask

   task automatic load_counting_data();
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
   endtask

   initial begin
      #3;
      check_beat("reset", 1'b0, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full rotation across all channels.
      load_counting_data();
      apply_stimulus(4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_beat("rotation", 1'b1, 8'h10 + 8'(i % N), i % N);
      end

      // Single channel keeps winning, wrap back to ch0 afterwards.
      apply_stimulus(4'b1000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_beat("single ch3", 1'b1, 8'h13, 3);
      end
      apply_stimulus(4'b0011, 1'b1);
      tick();
      check_beat("wrap ch0", 1'b1, 8'h10, 0);

      // Backpressure holds the register and blocks every channel.
      apply_stimulus(4'b1111, 1'b0);
      #1;
      check_output("stall in_ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_beat("stall", 1'b1, 8'h10, 0);
         check_output("stall in_ready", 32'(in_ready), 32'h0);
      end
      apply_stimulus(4'b1111, 1'b1);
      #1;
      check_output("release in_ready", 32'(in_ready), 32'b0010);
      tick();
      check_beat("release", 1'b1, 8'h11, 1);

      // Idle drain.
      apply_stimulus(4'b0000, 1'b1);
      tick();
      check_beat("drain", 1'b0, 8'h11, 1);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_MUX_LAST_EN
         in_last   = N'($urandom);
`endif
         tick();
      end

      // Asynchronous reset between edges while a beat is held.
      in_last = '1;
      load_counting_data();
      apply_stimulus(4'b1111, 1'b1);
      tick();
      check_output("pre-reset out_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_beat("async reset", 1'b0, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef RR_MUX_LAST_EN
      // Packet on ch0 with a gap must not let ch1 in until its last beat.
      in_last = 4'b1110;
      apply_stimulus(4'b0011, 1'b1);
      tick();
      check_beat("pkt beat1", 1'b1, 8'h10, 0);
      check_output("pkt beat1 last", 32'(out_last), 32'h0);
      apply_stimulus(4'b0010, 1'b1);
      tick();
      check_output("pkt bubble", 32'(out_valid), 32'h0);
      apply_stimulus(4'b0011, 1'b1);
      tick();
      check_beat("pkt beat2", 1'b1, 8'h10, 0);
      in_last = 4'b1111;
      tick();
      check_beat("pkt beat3", 1'b1, 8'h10, 0);
      check_output("pkt beat3 last", 32'(out_last), 32'h1);
      tick();
      check_beat("pkt then ch1", 1'b1, 8'h11, 1);
`endif

      apply_stimulus(4'b0000, 1'b1);
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
